pps_freq_counter: RTL
=====================

PPS_FREQ_COUNTER -- requirements
Module: pps_freq_counter

Interface
REQ-001 Parameter NOMINAL, default 20_000_000, expected CLK_SYS cycles per PPS period.
REQ-002 Parameter TIMEOUT, default 30_000_000, cycles without a PPS edge before loss is declared; constraint NOMINAL < TIMEOUT < 2^32.
REQ-003 Parameter LOCK_TOL, default 100, maximum |MEAS_ERR| counted as a good measurement.
REQ-004 Parameter LOCK_CNT, default 4, consecutive good measurements required for lock.
REQ-005 CLK_SYS  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-006 CLK_RST  input  1  reset, asynchronous, active-low.
REQ-007 PPS_IN  input  1  GPS 1PPS, asynchronous to CLK_SYS.
REQ-008 MEAS_CNT  output  32  CLK_SYS cycles between the last two PPS rising edges, unsigned.
REQ-009 MEAS_ERR  output  32  MEAS_CNT minus NOMINAL, two's complement.
REQ-010 MEAS_VALID  output  1  one-cycle pulse; MEAS_CNT/MEAS_ERR newly updated.
REQ-011 PPS_LOST  output  1  high while no PPS reference is tracked.
REQ-012 LOCKED  output  1  high when LOCK_CNT consecutive good measurements have been taken.
REQ-013 LED  output  1  status LED, active-low.

Function
REQ-014 PPS_IN SHALL pass through a 2-flop synchronizer plus one delay flop; pps_rise = sync2 & ~sync3, one cycle per rising edge regardless of PPS high time.
REQ-015 States: IDLE (no reference), RUN (measuring); reset enters IDLE.
REQ-016 IDLE: cycle counter held at 0; on pps_rise -> RUN, counter cleared, PPS_LOST cleared next cycle, no MEAS_VALID.
REQ-017 RUN: counter increments by 1 every cycle without pps_rise.
REQ-018 RUN, pps_rise: MEAS_CNT <= counter+1, MEAS_ERR <= counter+1-NOMINAL (32-bit wrap), MEAS_VALID = 1 in the following cycle only, counter <= 0.
REQ-019 Consequence: pps_rise pulses N cycles apart SHALL yield MEAS_CNT = N.
REQ-020 RUN, counter == TIMEOUT-1 without pps_rise: -> IDLE, PPS_LOST <= 1, LOCKED <= 0, good count <= 0, counter <= 0; MEAS_CNT/MEAS_ERR retain old values.
REQ-021 pps_rise in the same cycle as counter == TIMEOUT-1: pps_rise wins; measurement taken, no loss.
REQ-022 Good count: 0..LOCK_CNT, saturating; per measurement, if -LOCK_TOL <= MEAS_ERR <= LOCK_TOL (signed) increment, else clear to 0.
REQ-023 LOCKED = (good count == LOCK_CNT), updated in the same cycle MEAS_VALID is high.
REQ-024 LED: 0 (lit) steady while LOCKED; while not LOCKED, toggles on every pps_rise; held 1 while PPS_LOST.
REQ-025 MEAS_CNT, MEAS_ERR SHALL change only in MEAS_VALID cycles.

Reset
REQ-026 On CLK_RST low, immediately: state IDLE, counter 0, synchronizer flops 0, MEAS_CNT 0, MEAS_ERR 0, MEAS_VALID 0, PPS_LOST 1, LOCKED 0, good count 0, LED 1.
REQ-027 Reset asserted mid-measurement SHALL discard the partial count; first pps_rise after release only arms RUN.

Verification (NOMINAL=1000, TIMEOUT=1500, LOCK_TOL=2, LOCK_CNT=4)
REQ-028 PPS every 1000 cycles -> first edge: no MEAS_VALID, PPS_LOST 1->0; each later edge MEAS_CNT=1000, MEAS_ERR=0; LOCKED=1 and LED=0 with 4th MEAS_VALID.
REQ-029 Locked, then one period of 1003 -> MEAS_CNT=1003, MEAS_ERR=3, LOCKED=0 in that MEAS_VALID cycle; LED toggles on following edges.
REQ-030 Period 998 -> MEAS_ERR=0xFFFFFFFE, counted good; LOCKED stays/becomes 1.
REQ-031 PPS stopped -> 1500 cycles after last counted edge PPS_LOST=1, LOCKED=0, LED=1; next edge no MEAS_VALID; edge after that gives valid measurement.
REQ-032 PPS held high 50 cycles, period 1000 -> exactly one MEAS_VALID per period, MEAS_CNT=1000.
REQ-033 CLK_RST pulsed low mid-RUN -> all outputs at REQ-026 values without waiting for a clock edge.

Source files
------------

// File: rtl/pps_freq_counter.sv
// rtl/pps_freq_counter.sv - GPS 1PPS period counter with frequency error, lock and loss detection
module pps_freq_counter #(
    parameter int unsigned NOMINAL  = 20_000_000,
    parameter int unsigned TIMEOUT  = 30_000_000,
    parameter int unsigned LOCK_TOL = 100,
    parameter int unsigned LOCK_CNT = 4
) (
    input  logic        CLK_SYS,
    input  logic        CLK_RST,
    input  logic        PPS_IN,
    output logic [31:0] MEAS_CNT,
    output logic [31:0] MEAS_ERR,
    output logic        MEAS_VALID,
    output logic        PPS_LOST,
    output logic        LOCKED,
    output logic        LED
);

    localparam int                 GW       = $clog2(LOCK_CNT + 1);
    localparam logic [GW-1:0]      GOOD_MAX = GW'(LOCK_CNT);
    localparam logic [31:0]        NOM_W    = 32'(NOMINAL);
    localparam logic [31:0]        CNT_LAST = 32'(TIMEOUT - 1);
    localparam logic signed [31:0] TOL_HI   = $signed(32'(LOCK_TOL));
    localparam logic signed [31:0] TOL_LO   = -TOL_HI;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state;
    state_t          state_next;
    logic [2:0]      pps_sync;
    logic            pps_rise;
    logic            arm;
    logic            take;
    logic            lose;
    logic [31:0]     counter;
    logic [31:0]     meas_sum;
    logic [31:0]     meas_diff;
    logic            err_good;
    logic [GW-1:0]   good_cnt;
    logic [GW-1:0]   good_next;
    logic            locked_next;

    // Two synchronizer flops plus one delay flop for edge detection.
    always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
        if (!CLK_RST) begin
            pps_sync <= 3'b000;
        end else begin
            pps_sync <= {pps_sync[1:0], PPS_IN};
        end
    end

    assign pps_rise = pps_sync[1] & ~pps_sync[2];

    always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
        if (!CLK_RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pps_rise) state_next = RUN;
            RUN:     if (!pps_rise && (counter == CNT_LAST)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // An edge landing on the last counter value is still a measurement.
    always_comb begin
        arm  = 1'b0;
        take = 1'b0;
        lose = 1'b0;
        case (state)
            IDLE:    arm  = pps_rise;
            RUN: begin
                take = pps_rise;
                lose = !pps_rise && (counter == CNT_LAST);
            end
            default: ;
        endcase
    end

    always_comb begin
        meas_sum  = counter + 32'd1;
        meas_diff = meas_sum - NOM_W;
        err_good  = ($signed(meas_diff) >= TOL_LO) && ($signed(meas_diff) <= TOL_HI);
        if (!err_good) begin
            good_next = '0;
        end else if (good_cnt == GOOD_MAX) begin
            good_next = good_cnt;
        end else begin
            good_next = good_cnt + GW'(1);
        end
        locked_next = (good_next == GOOD_MAX);
    end

    always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
        if (!CLK_RST) begin
            counter    <= 32'd0;
            MEAS_CNT   <= 32'd0;
            MEAS_ERR   <= 32'd0;
            MEAS_VALID <= 1'b0;
            PPS_LOST   <= 1'b1;
            LOCKED     <= 1'b0;
            good_cnt   <= '0;
            LED        <= 1'b1;
        end else begin
            MEAS_VALID <= take;
            if (arm || take || lose || (state == IDLE)) begin
                counter <= 32'd0;
            end else begin
                counter <= meas_sum;
            end
            if (arm) begin
                PPS_LOST <= 1'b0;
            end
            if (take) begin
                MEAS_CNT <= meas_sum;
                MEAS_ERR <= meas_diff;
                good_cnt <= good_next;
                LOCKED   <= locked_next;
                LED      <= locked_next ? 1'b0 : ~LED;
            end
            if (lose) begin
                PPS_LOST <= 1'b1;
                LOCKED   <= 1'b0;
                good_cnt <= '0;
                LED      <= 1'b1;
            end
        end
    end

endmodule
